// File: rtl/prefix_sum_stage.sv
// prefix_sum_stage: final parallel-prefix adder stage; group carries, in-group ripple and flags behind a 2-deep valid/ready pipeline
module prefix_sum_stage #(
  parameter int INPUTSIZE = 32,
  parameter int GROUPSIZE = 4,
  localparam int TREESIZE = INPUTSIZE / GROUPSIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INPUTSIZE-1:0]  p,
  input  logic [INPUTSIZE-1:0]  g,
  input  logic [2*TREESIZE-1:0] gp_prefix,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [INPUTSIZE-1:0]  sum,
  output logic                  cout,
  output logic                  overflow,
  output logic                  zero
);
  logic                 r_a_valid;
  logic [INPUTSIZE-1:0] r_a_p, r_a_g;
  logic [TREESIZE-1:0]  r_a_cg;
  logic                 r_a_cout;
  logic [TREESIZE-1:0]  w_cg;
  logic                 w_cout, w_b_load, w_in_xfer, w_ripple;
  logic [INPUTSIZE-1:0] w_c, w_sum;
  // group prefixes exclude cin, so fold it in here
  always_comb begin
    w_cg = '0;
    w_cg[0] = cin;
    for (int k = 1; k < TREESIZE; k++) w_cg[k] = gp_prefix[2*k-1] | (gp_prefix[2*k-2] & cin);
  end
  assign w_cout = gp_prefix[2*TREESIZE-1] | (gp_prefix[2*TREESIZE-2] & cin);
  always_comb begin
    w_ripple = 1'b0;
    w_c = '0;
    for (int i = 0; i < INPUTSIZE; i++) begin
      w_ripple = (i % GROUPSIZE == 0) ? r_a_cg[i / GROUPSIZE] : w_ripple;
      w_c[i] = w_ripple;
      w_ripple = r_a_g[i] | (r_a_p[i] & w_ripple);
    end
  end
  assign w_sum     = r_a_p ^ w_c;
  assign w_b_load  = ~out_valid | out_ready;
  assign in_ready  = ~r_a_valid | w_b_load;
  assign w_in_xfer = in_valid & in_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_a_p     <= '0;
      r_a_g     <= '0;
      r_a_cg    <= '0;
      r_a_cout  <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      if (in_ready) r_a_valid <= in_valid;
      if (w_in_xfer) begin
        r_a_p    <= p;
        r_a_g    <= g;
        r_a_cg   <= w_cg;
        r_a_cout <= w_cout;
      end
      if (w_b_load) out_valid <= r_a_valid;
      if (w_b_load & r_a_valid) begin
        sum      <= w_sum;
        cout     <= r_a_cout;
        overflow <= w_c[INPUTSIZE-1] ^ r_a_cout;
        zero     <= ~|w_sum;
      end
    end
  end
endmodule

// File: tb/tb_prefix_sum_stage.sv
// tb_prefix_sum_stage: directed and randomized checks of prefix_sum_stage against an arithmetic scoreboard
module tb_prefix_sum_stage;
  logic        clk, rst, in_valid, in_ready, cin, out_valid, out_ready, cout, overflow, zero;
  logic [31:0] p, g, sum;
  logic [15:0] gp_prefix;
  typedef struct packed {logic [31:0] s; logic co, ov, z;} exp_t;
  exp_t        q[$];
  int          n_cmp = 0, n_bad = 0;
  bit          held_ok = 0;
  logic [31:0] h_sum;
  logic [2:0]  h_fl;

  prefix_sum_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .p(p), .g(g),
    .gp_prefix(gp_prefix), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow), .zero(zero));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic ci);
    logic [32:0] t;
    exp_t e;
    t = {1'b0, a} + {1'b0, b} + {32'd0, ci};
    e.s = t[31:0];
    e.co = t[32];
    e.ov = (a[31] == b[31]) && (t[31] != a[31]);
    e.z = (t[31:0] == 32'd0);
    return e;
  endfunction

  // group k: G = carry out of the low 4k+4 bits with no carry-in, P = those bits all propagate
  function automatic logic [15:0] gp_of(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] m, sm;
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      m = (64'd1 << (4*k+4)) - 64'd1;
      sm = ({32'd0, a} & m) + ({32'd0, b} & m);
      r[2*k+1] = sm[4*k+4];
      r[2*k] = (({32'd0, a ^ b} & m) == m);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b, input bit ci,
                      input bit ordy, output bit acc, output bit ovs);
    exp_t e;
    in_valid = v; p = a ^ b; g = a & b; gp_prefix = gp_of(a, b); cin = ci; out_ready = ordy;
    #3;
    if (held_ok) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", sum, h_sum);
      chk("hold_flags", {cout, overflow, zero}, h_fl);
    end
    held_ok = out_valid && !out_ready;
    h_sum = sum;
    h_fl = {cout, overflow, zero};
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("stale_out", out_valid, 0);
      else begin
        e = q.pop_front();
        chk("sum", sum, e.s);
        chk("flags", {cout, overflow, zero}, {e.co, e.ov, e.z});
      end
    end
    acc = in_valid && in_ready;
    ovs = out_valid;
    if (acc) q.push_back(model(a, b, ci));
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ovalid"}, out_valid, 0);
    chk({tag, "_sum"}, sum, 0);
    chk({tag, "_flags"}, {cout, overflow, zero}, 0);
    chk({tag, "_iready"}, in_ready, 1);
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b, input bit ci,
                          input logic [31:0] es, input logic [2:0] ef);
    bit acc, ovs;
    step(1, a, b, ci, 1, acc, ovs);
    chk({tag, "_acc"}, acc, 1);
    step(0, 0, 0, 0, 1, acc, ovs);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_flags"}, {cout, overflow, zero}, ef);
    step(0, 0, 0, 0, 1, acc, ovs);
  endtask

  task automatic drain(input string tag);
    bit acc, ovs;
    for (int i = 0; i < 20 && q.size() != 0; i++) step(0, 0, 0, 0, 1, acc, ovs);
    chk({tag, "_drained"}, q.size(), 0);
  endtask

  initial begin
    bit acc, ovs;
    logic [31:0] a, b;
    bit ci, pend;
    int n_acc;
    rst = 1; in_valid = 0; p = 0; g = 0; gp_prefix = 0; cin = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #3 chk_reset("por");
    @(posedge clk); #1;

    directed("carry",  32'hFFFF_FFFF, 32'h0000_0001, 0, 32'h0000_0000, 3'b101);
    directed("ovf",    32'h7FFF_FFFF, 32'h0000_0001, 0, 32'h8000_0000, 3'b010);
    directed("sub",    32'h0000_0005, ~32'h0000_0003, 1, 32'h0000_0002, 3'b100);
    directed("cinone", 32'h0, 32'h0, 1, 32'h0000_0001, 3'b000);
    directed("allzer", 32'h0, 32'h0, 0, 32'h0000_0000, 3'b001);

    for (int j = 0; j < 18; j++) begin
      step(j < 16, $urandom, $urandom, 1'($urandom % 2), 1, acc, ovs);
      if (j < 16) chk("stream_acc", acc, 1);
      chk("stream_valid", ovs, j >= 2);
    end
    drain("stream");

    step(1, $urandom, $urandom, 0, 0, acc, ovs);
    chk("bp_acc0", acc, 1);
    step(1, $urandom, $urandom, 1, 0, acc, ovs);
    chk("bp_acc1", acc, 1);
    a = $urandom; b = $urandom;
    for (int j = 0; j < 3; j++) begin
      step(1, a, b, 1, 0, acc, ovs);
      chk("bp_block", acc, 0);
    end
    pend = 1;
    for (int j = 0; j < 10 && pend; j++) begin
      step(1, a, b, 1, 1, acc, ovs);
      pend = !acc;
    end
    chk("bp_third_acc", pend, 0);
    drain("bp");

    step(1, $urandom, $urandom, 0, 0, acc, ovs);
    step(1, $urandom, $urandom, 1, 0, acc, ovs);
    rst = 1; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    rst = 0; in_valid = 0;
    #3 chk_reset("midrst");
    q.delete();
    held_ok = 0;
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++) begin
      step(0, 0, 0, 0, 1, acc, ovs);
      chk("midrst_noout", ovs, 0);
    end

    n_acc = 0;
    a = $urandom; b = $urandom; ci = 1'($urandom % 2);
    for (int j = 0; j < 3000 && n_acc < 200; j++) begin
      step(($urandom % 4) != 0, a, b, ci, 1'($urandom % 2), acc, ovs);
      if (acc) begin
        n_acc++;
        a = ($urandom % 8 == 0) ? 32'hFFFF_FFFF : $urandom;
        b = ($urandom % 8 == 0) ? 32'h0 : $urandom;
        ci = 1'($urandom % 2);
      end
    end
    chk("rand_accepts", n_acc, 200);
    drain("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
